// File: rtl/regfile_dump_reader.sv
`default_nettype none
// ============================================================================
// Module   : regfile_dump_reader
// Purpose  : Debug readback engine. Sweeps a (possibly wrapping) range of
//            register-file entries through one combinational read port and
//            emits each entry as a (sel, data) beat on a valid/ready stream.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_dump_reader #(
  parameter int REG_DATA_WIDTH = 32,
  parameter int REG_SEL_BITS   = 5
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [REG_SEL_BITS-1:0]   first_sel,
  input  logic [REG_SEL_BITS-1:0]   last_sel,
  output logic [REG_SEL_BITS-1:0]   rf_read_sel,
  input  logic [REG_DATA_WIDTH-1:0] rf_read_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [REG_SEL_BITS-1:0]   out_sel,
  output logic [REG_DATA_WIDTH-1:0] out_data,
  output logic                      busy,
  output logic                      done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]              state;
  logic [1:0]              state_next;
  logic [REG_SEL_BITS-1:0] idx;
  logic [REG_SEL_BITS-1:0] last;
  logic                    load;
  logic                    accept;

  // The consumer takes the current beat on valid & ready.
  assign accept = out_valid & out_ready;

  // State register; reset aborts any sweep in progress.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: leave RUN once the beat for the last index is loaded,
  // leave DRAIN once that final beat is accepted.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start)                 state_next = ST_RUN;
      ST_RUN:   if (load && (idx == last)) state_next = ST_DRAIN;
      ST_DRAIN: if (accept)                state_next = ST_IDLE;
      default:                             state_next = ST_IDLE;
    endcase
  end

  // State-decoded outputs; the read port only points at idx while sweeping,
  // and a new beat loads whenever the 1-deep output slot is free or draining.
  always_comb begin
    rf_read_sel = '0;
    busy        = 1'b0;
    load        = 1'b0;
    case (state)
      ST_RUN: begin
        rf_read_sel = idx;
        busy        = 1'b1;
        load        = !out_valid || out_ready;
      end
      ST_DRAIN: begin
        busy        = 1'b1;
      end
      default: begin
        busy        = 1'b0;
      end
    endcase
  end

  // Datapath: sweep bounds, index walk, output beat register and done pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      idx       <= '0;
      last      <= '0;
      out_valid <= 1'b0;
      out_sel   <= '0;
      out_data  <= '0;
      done      <= 1'b0;
    end else begin
      done <= (state == ST_DRAIN) && accept;
      if ((state == ST_IDLE) && start) begin
        idx  <= first_sel;
        last <= last_sel;
      end
      if (load) begin
        // Each beat captures the register as it reads in this cycle; idx
        // wraps naturally at the top of the file.
        out_data  <= rf_read_data;
        out_sel   <= idx;
        out_valid <= 1'b1;
        idx       <= idx + 1'b1;
      end else if (accept) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_dump_reader
// Purpose  : Self-checking bench for regfile_dump_reader with a behavioural
//            register file and an expected-beat queue per sweep.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  first_sel;
  logic [4:0]  last_sel;
  logic [4:0]  rf_read_sel;
  logic [31:0] rf_read_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_sel;
  logic [31:0] out_data;
  logic        busy;
  logic        done;

  logic [31:0] mem [32];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  assign rf_read_data = mem[rf_read_sel];

  regfile_dump_reader #(.REG_DATA_WIDTH(32), .REG_SEL_BITS(5)) dut (
    .clock        (clk),
    .reset        (reset),
    .start        (start),
    .first_sel    (first_sel),
    .last_sel     (last_sel),
    .rf_read_sel  (rf_read_sel),
    .rf_read_data (rf_read_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sel      (out_sel),
    .out_data     (out_data),
    .busy         (busy),
    .done         (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // mode 0: ready always high; 1: random ready; 2: ready low 3 cycles on beat 2.
  // poke: write r3=0x99 before it loads and pulse start while busy.
  task automatic run_sweep(input logic [4:0] f, input logic [4:0] l, input int mode, input bit poke);
    logic [4:0]  exp_sel [$];
    logic [4:0]  hold_sel;
    logic [31:0] hold_data;
    logic [4:0]  span;
    int          n, k, cyc, stall_cnt;
    bit          stalled;
    span = l - f;
    n = int'(span) + 1;
    for (int i = 0; i < n; i++) exp_sel.push_back(f + 5'(i));
    @(negedge clk);
    start = 1'b1; first_sel = f; last_sel = l; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_after_start", 32'(busy), 32'd1);
    check_eq("valid_before_load", 32'(out_valid), 32'd0);
    if (poke) mem[3] = 32'h99;
    k = 0; cyc = 0; stall_cnt = 0; stalled = 1'b0;
    hold_sel = '0; hold_data = '0;
    while (k < n && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check_eq("first_beat_latency", 32'(out_valid), 32'd1);
      if (poke && cyc == 2) begin
        start = 1'b1; first_sel = 5'd0; last_sel = 5'd31;
      end else begin
        start = 1'b0;
      end
      if (stalled) begin
        check_eq("stall_hold_valid", 32'(out_valid), 32'd1);
        check_eq("stall_hold_sel", 32'(out_sel), 32'(hold_sel));
        check_eq("stall_hold_data", out_data, hold_data);
      end
      if (out_valid) check_eq("done_while_beats", 32'(done), 32'd0);
      if (out_valid && k == n - 1) check_eq("read_sel_drain", 32'(rf_read_sel), 32'd0);
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = !(k == 1 && out_valid && stall_cnt < 3);
      endcase
      if (mode == 0) check_eq("full_throughput", 32'(out_valid), 32'd1);
      if (out_valid && out_ready) begin
        check_eq("beat_sel", 32'(out_sel), 32'(exp_sel[k]));
        check_eq("beat_data", out_data, mem[exp_sel[k]]);
        k++;
        stalled = 1'b0;
      end else begin
        stalled   = out_valid;
        hold_sel  = out_sel;
        hold_data = out_data;
        if (mode == 2 && k == 1 && out_valid) stall_cnt++;
      end
    end
    if (k < n) check_eq("sweep_timeout_beats", 32'(k), 32'(n));
    @(negedge clk);
    start = 1'b0;
    check_eq("done_pulse", 32'(done), 32'd1);
    check_eq("busy_low_at_done", 32'(busy), 32'd0);
    check_eq("valid_dropped", 32'(out_valid), 32'd0);
    check_eq("read_sel_idle", 32'(rf_read_sel), 32'd0);
    @(negedge clk);
    check_eq("done_single_cycle", 32'(done), 32'd0);
    check_eq("stays_idle", 32'(busy), 32'd0);
    check_eq("no_extra_beat", 32'(out_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; first_sel = '0; last_sel = '0; out_ready = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    mem[0] = 32'h0;
    mem[1] = 32'h11; mem[2] = 32'h22; mem[3] = 32'h33;
    repeat (3) @(negedge clk);
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_read_sel", 32'(rf_read_sel), 32'd0);
    check_eq("rst_out_sel", 32'(out_sel), 32'd0);
    check_eq("rst_out_data", out_data, 32'd0);
    reset = 1'b0;

    // Basic, stalled, wrapping and single-entry sweeps.
    run_sweep(5'd1, 5'd3, 0, 1'b0);
    run_sweep(5'd1, 5'd3, 2, 1'b0);
    run_sweep(5'd30, 5'd1, 0, 1'b0);
    run_sweep(5'd5, 5'd5, 0, 1'b0);

    // Reset while beat 2 of a 1..3 sweep is presented.
    @(negedge clk);
    start = 1'b1; first_sel = 5'd1; last_sel = 5'd3; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_beat1", 32'(out_sel), 32'd1);
    @(negedge clk);
    check_eq("rst_mid_beat2", 32'(out_sel), 32'd2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("rst_mid_valid", 32'(out_valid), 32'd0);
    check_eq("rst_mid_busy", 32'(busy), 32'd0);
    check_eq("rst_mid_done", 32'(done), 32'd0);
    @(negedge clk);
    check_eq("rst_mid_no_done", 32'(done), 32'd0);
    check_eq("rst_mid_idle", 32'(busy), 32'd0);
    run_sweep(5'd1, 5'd3, 0, 1'b0);

    // Start while busy is ignored; a write lands before r3 is loaded.
    run_sweep(5'd1, 5'd3, 0, 1'b1);

    // Start asserted together with reset is ignored.
    @(negedge clk);
    reset = 1'b1; start = 1'b1; first_sel = 5'd2; last_sel = 5'd4;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check_eq("start_in_reset_ignored", 32'(busy), 32'd0);
    check_eq("start_in_reset_no_valid", 32'(out_valid), 32'd0);

    // Randomized sweeps with random backpressure over fresh register contents.
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 32; i++) mem[i] = $urandom;
      run_sweep(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
